fb_write_scheduler: RTL



---
 rtl/fb_write_scheduler_if.sv | 51 +++++
 rtl/fb_write_scheduler.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/fb_write_scheduler_if.sv
// Frame buffer write scheduler bus: two pixel requesters, clear control, GPU write port.
// Latency: none (signal bundle only).
// Backpressure: requesters see reqN_ready; the frame buffer write port has no backpressure.
//
// Ports (modports):
//   master - drives pixel requests and clear control; observes readies, status and the write port
//   slave  - the scheduler; drives readies, status and the frame buffer write port
interface fb_write_scheduler_if #(
    parameter int ADDR_W = 17,
    parameter int DATA_W = 4
);
    logic              req0_valid;
    logic              req0_ready;
    logic [8:0]        req0_x;
    logic [7:0]        req0_y;
    logic [DATA_W-1:0] req0_color;

    logic              req1_valid;
    logic              req1_ready;
    logic [8:0]        req1_x;
    logic [7:0]        req1_y;
    logic [DATA_W-1:0] req1_color;

    logic              clear_start;
    logic [DATA_W-1:0] clear_color;
    logic              busy;
    logic              clear_done;
    logic              oob_drop;

    logic [ADDR_W-1:0] gpu_pixel_addr;
    logic [DATA_W-1:0] gpu_pixel_data;
    logic              gpu_we;

    modport master (
        output req0_valid, req0_x, req0_y, req0_color,
        output req1_valid, req1_x, req1_y, req1_color,
        output clear_start, clear_color,
        input  req0_ready, req1_ready,
        input  busy, clear_done, oob_drop,
        input  gpu_pixel_addr, gpu_pixel_data, gpu_we
    );

    modport slave (
        input  req0_valid, req0_x, req0_y, req0_color,
        input  req1_valid, req1_x, req1_y, req1_color,
        input  clear_start, clear_color,
        output req0_ready, req1_ready,
        output busy, clear_done, oob_drop,
        output gpu_pixel_addr, gpu_pixel_data, gpu_we
    );
endinterface

// File: rtl/fb_write_scheduler.sv
// Single write master for the frame buffer: round-robin over two pixel requesters plus a full-screen clear engine.
// Latency: accepted pixel is written 1 cycle after acceptance; clear writes one pixel per clock for WIDTH*HEIGHT cycles.
// Backpressure: readies are combinational grants; both are held low while clearing or while clear_start is high.
//
// Ports:
//   gpu_clk - sole clock
//   rst     - synchronous active-high reset
//   bus     - slave side of fb_write_scheduler_if (requests, clear control, status, write port)
module fb_write_scheduler #(
    parameter int WIDTH  = 320,
    parameter int HEIGHT = 240,
    parameter int ADDR_W = 17,
    parameter int DATA_W = 4
) (
    input  logic                 gpu_clk,
    input  logic                 rst,
    fb_write_scheduler_if.slave  bus
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(WIDTH * HEIGHT - 1);

    typedef enum logic {
        IDLE,
        CLEAR
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [ADDR_W-1:0] counter;
    logic [DATA_W-1:0] fill_color;
    logic              last_grant;

    logic              grant0;
    logic              grant1;
    logic              accept0;
    logic              accept1;
    logic              accept_any;
    logic              clear_last;

    logic [8:0]        sel_x;
    logic [7:0]        sel_y;
    logic [DATA_W-1:0] sel_color;
    logic              in_range;
    logic [ADDR_W-1:0] lin_addr;

    // Registered result of the pixel path; the clear engine overrides it while in CLEAR.
    logic              pix_we;
    logic              pix_oob;
    logic [ADDR_W-1:0] pix_addr;
    logic [DATA_W-1:0] pix_data;

    // Round robin: on contention the requester that did not win last time gets the grant.
    always_comb begin
        grant0 = bus.req0_valid && (!bus.req1_valid || last_grant);
        grant1 = bus.req1_valid && (!bus.req0_valid || !last_grant);
    end

    assign bus.req0_ready = (state == IDLE) && !bus.clear_start && grant0;
    assign bus.req1_ready = (state == IDLE) && !bus.clear_start && grant1;

    assign accept0    = bus.req0_valid && bus.req0_ready;
    assign accept1    = bus.req1_valid && bus.req1_ready;
    assign accept_any = accept0 || accept1;

    always_comb begin
        sel_x     = accept1 ? bus.req1_x     : bus.req0_x;
        sel_y     = accept1 ? bus.req1_y     : bus.req0_y;
        sel_color = accept1 ? bus.req1_color : bus.req0_color;
        in_range  = (32'(sel_x) < WIDTH) && (32'(sel_y) < HEIGHT);
        lin_addr  = ADDR_W'(sel_y) * ADDR_W'(WIDTH) + ADDR_W'(sel_x);
    end

    assign clear_last = (state == CLEAR) && (counter == LAST_ADDR);

    always_ff @(posedge gpu_clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // clear_start seen while already clearing has no effect.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.clear_start) state_nxt = CLEAR;
            CLEAR:   if (clear_last)      state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge gpu_clk) begin
        if (rst) begin
            counter    <= '0;
            fill_color <= '0;
            last_grant <= 1'b1;
            pix_we     <= 1'b0;
            pix_oob    <= 1'b0;
            pix_addr   <= '0;
            pix_data   <= '0;
        end else begin
            pix_we  <= 1'b0;
            pix_oob <= 1'b0;

            if ((state == IDLE) && bus.clear_start) begin
                counter    <= '0;
                fill_color <= bus.clear_color;
            end else if (state == CLEAR) begin
                if (clear_last) begin
                    counter  <= '0;
                    // Keep the write port showing the final clear write once the engine lets go.
                    pix_addr <= counter;
                    pix_data <= fill_color;
                end else begin
                    counter <= counter + 1'b1;
                end
            end

            // Acceptance only happens in IDLE, so it never collides with the clear updates above.
            if (accept_any) begin
                last_grant <= accept1;
                if (in_range) begin
                    pix_we   <= 1'b1;
                    pix_addr <= lin_addr;
                    pix_data <= sel_color;
                end else begin
                    pix_oob  <= 1'b1;
                end
            end
        end
    end

    assign bus.busy           = (state == CLEAR);
    assign bus.clear_done     = clear_last;
    assign bus.oob_drop       = pix_oob;
    assign bus.gpu_we         = pix_we || (state == CLEAR);
    assign bus.gpu_pixel_addr = (state == CLEAR) ? counter    : pix_addr;
    assign bus.gpu_pixel_data = (state == CLEAR) ? fill_color : pix_data;

endmodule
